// File: rtl/n64_poll_ctrl.sv
// N64 controller poll engine: sends the 0x01 status command periodically or on request and captures the reply.
// Define N64_POLL_ERRCNT_EN to add the saturating timeout counter output err_cnt.
module n64_poll_ctrl #(
    parameter int POLL_TICKS    = 66667,
    parameter int TIMEOUT_TICKS = 800,
    parameter int GAP_TICKS     = 8
) (
    input  logic        clk_4M,
    input  logic        reset,
    input  logic        poll_req,
    input  logic        rx_done,
    input  logic [31:0] rx_state,
    output logic        dout,
    output logic        dout_oe,
    output logic        rx_enable,
    output logic        busy,
    output logic [31:0] ctrl_state,
    output logic        state_valid,
    output logic        timeout_err,
`ifdef N64_POLL_ERRCNT_EN
    output logic [7:0]  err_cnt,
`endif
    output logic [2:0]  dbg_state
);

    localparam int PW = 17;
    localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [7:0] POLL_CMD = 8'h01;

    // dbg_state exposes this encoding directly; IDLE is 0.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TX_BIT    = 3'd1,
        S_TX_STOP   = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   period_cnt;
    logic [1:0]      sync_ff;
    logic            sync_q;
    logic [4:0]      tx_cnt;
    logic [TW-1:0]   wait_cnt;
    logic [GW-1:0]   gap_cnt;

    logic wrap, trigger, done, cmd_bit;
    logic take_resp, take_tout;

    // No back-pressure anywhere: poll_req is a one-cycle strobe honoured only in IDLE,
    // and rx_done is treated as a level whose synchronised rising edge means "reply ready".
    assign wrap    = (period_cnt == PW'(POLL_TICKS - 1));
    assign trigger = wrap | poll_req;
    assign done    = sync_ff[1] & ~sync_q;
    assign cmd_bit = POLL_CMD[3'd7 - tx_cnt[4:2]];

    assign dbg_state = state;

    always_comb begin
        state_next = state;
        take_resp  = 1'b0;
        take_tout  = 1'b0;
        dout       = 1'b1;
        dout_oe    = 1'b0;
        rx_enable  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (trigger) state_next = S_TX_BIT;
            end
            S_TX_BIT: begin
                dout_oe = 1'b1;
                case (tx_cnt[1:0])
                    2'd0:    dout = 1'b0;
                    2'd3:    dout = 1'b1;
                    default: dout = cmd_bit;
                endcase
                if (tx_cnt == 5'd31) state_next = S_TX_STOP;
            end
            S_TX_STOP: begin
                dout_oe    = 1'b1;
                dout       = 1'b0;
                state_next = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                rx_enable = 1'b1;
                // A reply arriving on the final wait cycle still counts as a reply.
                if (done) begin
                    take_resp  = 1'b1;
                    state_next = S_GAP;
                end else if (wait_cnt == TW'(TIMEOUT_TICKS - 1)) begin
                    take_tout  = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP_TICKS - 1)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_4M) begin
        if (reset) begin
            state       <= S_IDLE;
            period_cnt  <= '0;
            sync_ff     <= 2'b00;
            sync_q      <= 1'b0;
            tx_cnt      <= 5'd0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            ctrl_state  <= 32'h0;
            state_valid <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            period_cnt  <= wrap ? '0 : period_cnt + PW'(1);
            sync_ff     <= {sync_ff[0], rx_done};
            sync_q      <= sync_ff[1];
            tx_cnt      <= (state == S_TX_BIT) ? tx_cnt + 5'd1 : 5'd0;
            wait_cnt    <= (state == S_WAIT_RESP) ? wait_cnt + TW'(1) : '0;
            gap_cnt     <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
            state_valid <= take_resp;
            timeout_err <= take_tout;
            if (take_resp) ctrl_state <= rx_state;
        end
    end

`ifdef N64_POLL_ERRCNT_EN
    always_ff @(posedge clk_4M) begin
        if (reset) begin
            err_cnt <= 8'd0;
        end else if (take_resp) begin
            err_cnt <= 8'd0;
        end else if (take_tout && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_n64_poll_ctrl.sv
// Bench for n64_poll_ctrl: timeline reference model checked every cycle, plus scoreboard of captured replies.
// With N64_POLL_ERRCNT_EN defined, a second short-timeout instance exercises err_cnt saturation.
module tb_n64_poll_ctrl;

    localparam int P    = 100;
    localparam int TO   = 800;
    localparam int GAP  = 8;
    localparam int NEVER = 100000;

    logic        clk_4M = 1'b0;
    logic        reset, poll_req, rx_done;
    logic [31:0] rx_state;
    logic        dout, dout_oe, rx_enable, busy, state_valid, timeout_err;
    logic [31:0] ctrl_state;
    logic [2:0]  dbg_state;
`ifdef N64_POLL_ERRCNT_EN
    logic [7:0]  err_cnt;
    logic        sat_reset, sat_poll_req, sat_rx_done;
    logic [31:0] sat_rx_state;
    logic        sat_dout, sat_dout_oe, sat_rx_enable, sat_busy, sat_state_valid, sat_timeout_err;
    logic [31:0] sat_ctrl_state;
    logic [2:0]  sat_dbg_state;
    logic [7:0]  sat_err_cnt;
    int          sat_base, sat_s;
`endif

    n64_poll_ctrl #(.POLL_TICKS(P), .TIMEOUT_TICKS(TO), .GAP_TICKS(GAP)) u_dut (
        .clk_4M(clk_4M), .reset(reset), .poll_req(poll_req), .rx_done(rx_done),
        .rx_state(rx_state), .dout(dout), .dout_oe(dout_oe), .rx_enable(rx_enable),
        .busy(busy), .ctrl_state(ctrl_state), .state_valid(state_valid),
        .timeout_err(timeout_err),
`ifdef N64_POLL_ERRCNT_EN
        .err_cnt(err_cnt),
`endif
        .dbg_state(dbg_state)
    );

`ifdef N64_POLL_ERRCNT_EN
    n64_poll_ctrl #(.POLL_TICKS(80), .TIMEOUT_TICKS(16), .GAP_TICKS(8)) u_sat (
        .clk_4M(clk_4M), .reset(sat_reset), .poll_req(sat_poll_req), .rx_done(sat_rx_done),
        .rx_state(sat_rx_state), .dout(sat_dout), .dout_oe(sat_dout_oe),
        .rx_enable(sat_rx_enable), .busy(sat_busy), .ctrl_state(sat_ctrl_state),
        .state_valid(sat_state_valid), .timeout_err(sat_timeout_err),
        .err_cnt(sat_err_cnt), .dbg_state(sat_dbg_state)
    );
`endif

    // clock / reset
    always #5 clk_4M = ~clk_4M;

    // reference model: everything is expressed as edge numbers relative to a transaction start
    int          cyc = 0, base = 0;
    int          s_edge = -1, end_edge = -1, done_edge = -1;
    bit          prev_smp = 1'b0;
    logic [31:0] m_ctrl = 32'h0;
    int          m_err = 0;
    bit          exp_valid, exp_tout;
    logic        exp_pat [0:32];
    logic [31:0] exp_q[$];

    int   checks = 0, errors = 0;
    int   obs_s = 0, obs_w0 = 0;
    logic prev_oe = 1'b0, prev_rxen = 1'b0;
    bit   freerun_armed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic        pr, rd, rst;
        logic [31:0] rs;
        logic        e_oe, e_dout, e_rxen, e_busy;
        int          k, w0;
        pr = poll_req; rd = rx_done; rst = reset; rs = rx_state;
        @(posedge clk_4M);
        cyc++;
        exp_valid = 1'b0;
        exp_tout  = 1'b0;
        if (rst) begin
            base = cyc; s_edge = -1; end_edge = -1; done_edge = -1;
            prev_smp = 1'b0; m_ctrl = 32'h0; m_err = 0;
        end else begin
            if (rd && !prev_smp) done_edge = cyc + 2;
            prev_smp = rd;
            if (s_edge >= 0) begin
                w0 = s_edge + 33;
                if (end_edge < 0 && cyc > w0) begin
                    if (done_edge == cyc) begin
                        end_edge = cyc; exp_valid = 1'b1; m_ctrl = rs; m_err = 0;
                        exp_q.push_back(rs);
                    end else if (cyc == w0 + TO) begin
                        end_edge = cyc; exp_tout = 1'b1;
                        if (m_err < 255) m_err++;
                    end
                end else if (end_edge >= 0 && cyc == end_edge + GAP) begin
                    s_edge = -1; end_edge = -1;
                end
            end else if (pr || (cyc > base && ((cyc - base) % P) == 0)) begin
                s_edge = cyc;
            end
        end
        e_oe = 1'b0; e_dout = 1'b1; e_rxen = 1'b0; e_busy = (s_edge >= 0);
        if (s_edge >= 0) begin
            k = cyc - s_edge;
            if (k <= 32) begin
                e_oe = 1'b1; e_dout = exp_pat[k];
            end else if (end_edge < 0) begin
                e_rxen = 1'b1;
            end
        end
        #1;
        chk("dout_oe", dout_oe, e_oe);
        chk("dout", dout, e_dout);
        chk("rx_enable", rx_enable, e_rxen);
        chk("busy", busy, e_busy);
        chk("state_valid", state_valid, exp_valid);
        chk("timeout_err", timeout_err, exp_tout);
        chk("ctrl_state", ctrl_state, m_ctrl);
        chk("dbg_idle", (dbg_state == 3'd0), !e_busy);
`ifdef N64_POLL_ERRCNT_EN
        chk("err_cnt", err_cnt, m_err);
`endif
        // scoreboard and interval checks on what the DUT actually did
        if (dout_oe === 1'b1 && prev_oe !== 1'b1) begin
            if (freerun_armed) chk("poll_period", cyc - obs_s, P);
            obs_s = cyc;
        end
        if (rx_enable === 1'b1 && prev_rxen !== 1'b1) begin
            chk("drive_len", cyc - obs_s, 33);
            obs_w0 = cyc;
        end
        if (timeout_err === 1'b1) chk("tout_delay", cyc - obs_w0, TO);
        if (state_valid === 1'b1) begin
            chk("sb_nonempty", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) chk("sb_ctrl", ctrl_state, exp_q.pop_front());
        end
        prev_oe   = dout_oe;
        prev_rxen = rx_enable;
    endtask

    // driver tasks
    task automatic start_txn();
        for (int i = 0; i < 2000 && s_edge >= 0; i++) step();
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        chk("txn_started", (s_edge >= 0), 1'b1);
    endtask

    task automatic wait_active();
        for (int i = 0; i < 300 && s_edge < 0; i++) step();
        chk("wrap_started", (s_edge >= 0), 1'b1);
    endtask

    // d: cycles into WAIT_RESP at which rx_done rises (negative = during TX, NEVER = no reply)
    task automatic run_txn(input int d, input logic [31:0] val, input bit poke);
        int k;
        for (int i = 0; i < 2000 && s_edge >= 0; i++) begin
            k = cyc - s_edge;
            poll_req = poke && (k == 10);
            if (end_edge >= 0 && cyc == end_edge + 2) poll_req = poke;
            if (k == 33 + d) begin
                rx_state = val;
                rx_done  = 1'b1;
            end
            step();
        end
        chk("txn_done", (s_edge < 0), 1'b1);
        poll_req = 1'b0;
        rx_done  = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int d;
        reset = 1'b1; poll_req = 1'b0; rx_done = 1'b0; rx_state = 32'h0;
`ifdef N64_POLL_ERRCNT_EN
        sat_reset = 1'b1; sat_poll_req = 1'b0; sat_rx_done = 1'b0; sat_rx_state = 32'h1234_5678;
`endif
        for (int g = 0; g < 8; g++) begin
            exp_pat[4*g]   = 1'b0;
            exp_pat[4*g+1] = (g == 7);
            exp_pat[4*g+2] = (g == 7);
            exp_pat[4*g+3] = 1'b1;
        end
        exp_pat[32] = 1'b0;

        repeat (3) step();
        reset = 1'b0;

        // manual poll, reply 100 cycles into the wait window
        start_txn();
        run_txn(100, 32'h8000_00FF, 1'b0);
        // no reply at all
        start_txn();
        run_txn(NEVER, $urandom, 1'b0);
        // reply lands on the timeout cycle: reply wins
        start_txn();
        run_txn(797, $urandom, 1'b1);
        // reply one cycle too late: timeout, then ignored in GAP
        start_txn();
        run_txn(798, $urandom, 1'b0);
        // reply during TX is ignored
        start_txn();
        run_txn(-20, $urandom, 1'b1);

        repeat (10) begin
            repeat ($urandom_range(0, 6)) step();
            start_txn();
            if ($urandom_range(0, 3) == 0) d = NEVER;
            else d = $urandom_range(0, 300);
            run_txn(d, $urandom, bit'($urandom_range(0, 1)));
        end

        // free-running polls only
        wait_active();
        run_txn(2, $urandom, 1'b0);
        freerun_armed = 1'b1;
        repeat (3) begin
            wait_active();
            run_txn(2, $urandom, 1'b0);
        end
        freerun_armed = 1'b0;

        // reset 10 cycles into TX_BIT
        start_txn();
        repeat (10) step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        start_txn();
        run_txn(50, $urandom, 1'b0);

`ifdef N64_POLL_ERRCNT_EN
        step();
        sat_base  = cyc;
        sat_reset = 1'b0;
        for (int k = 1; k <= 258; k++) begin
            while (cyc < sat_base + 80 * k + 49) step();
            chk("sat_tout", sat_timeout_err, 1'b1);
            chk("sat_err_cnt", sat_err_cnt, (k > 255) ? 255 : k);
        end
        sat_s = sat_base + 80 * 259;
        while (cyc < sat_s + 34) step();
        sat_rx_done = 1'b1;
        while (cyc < sat_s + 37) step();
        chk("sat_valid", sat_state_valid, 1'b1);
        chk("sat_err_clr", sat_err_cnt, 8'd0);
        chk("sat_ctrl", sat_ctrl_state, 32'h1234_5678);
        sat_rx_done = 1'b0;
        repeat (3) step();
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/n64_poll_ctrl.md
N64_POLL_CTRL -- requirements
Module: n64_poll_ctrl

Interface
REQ-001 Parameter POLL_TICKS, default 66667, clk_4M cycles between automatic polls (~60 Hz).
REQ-002 Parameter TIMEOUT_TICKS, default 800, cycles allowed for a response after line release (200 us).
REQ-003 Parameter GAP_TICKS, default 8, quiet cycles after each transaction before returning to IDLE.
REQ-004 clk_4M  input  1  4 MHz clock; sole clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 poll_req  input  1  single-cycle manual poll request.
REQ-007 rx_done  input  1  receiver completion flag from another clock domain; asynchronous to clk_4M.
REQ-008 rx_state  input  32  receiver controller state; stable while rx_done is high.
REQ-009 dout  output  1  line drive value.
REQ-010 dout_oe  output  1  line drive enable; line is released when low.
REQ-011 rx_enable  output  1  receiver sampling enable.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 ctrl_state  output  32  last valid controller state.
REQ-014 state_valid  output  1  one-cycle pulse when ctrl_state updates.
REQ-015 timeout_err  output  1  one-cycle pulse when a response is missed.

Function
REQ-016 The 17-bit period counter SHALL count 0..POLL_TICKS-1 and wrap, running in every state; wrap-cycle SHALL raise poll trigger.
REQ-017 Trigger = wrap OR poll_req; SHALL be acted on only in IDLE, dropped otherwise (no queueing).
REQ-018 States: IDLE, TX_BIT, TX_STOP, WAIT_RESP, GAP.
REQ-019 IDLE -> TX_BIT on trigger; dout_oe=0, rx_enable=0.
REQ-020 TX_BIT SHALL send 8'h01 MSB first, 4 cycles per bit; phase 0 dout=0; phases 1-2 dout=0 for bit 0, 1 for bit 1; phase 3 dout=1; dout_oe=1.
REQ-021 TX_STOP SHALL drive dout=0, dout_oe=1 for exactly 1 cycle, then enter WAIT_RESP; total drive time is 33 cycles.
REQ-022 WAIT_RESP SHALL hold dout_oe=0, rx_enable=1, and count cycles from 0.
REQ-023 rx_done SHALL pass through a 2-FF synchronizer; the rising edge of the synchronized signal is "done".
REQ-024 done in WAIT_RESP SHALL latch rx_state into ctrl_state, pulse state_valid in the same cycle, enter GAP.
REQ-025 Count reaching TIMEOUT_TICKS-1 without done SHALL pulse timeout_err, keep ctrl_state unchanged, enter GAP.
REQ-026 done and timeout in the same cycle: done wins; no timeout_err.
REQ-027 done outside WAIT_RESP SHALL be ignored.
REQ-028 GAP SHALL hold dout_oe=0, rx_enable=0 for GAP_TICKS cycles, then enter IDLE.
REQ-029 dout SHALL be 1 whenever dout_oe=0.

Reset
REQ-030 reset SHALL, at the next clk_4M edge and from any state, force IDLE, period counter=0, synchronizer=0, dout=1, dout_oe=0, rx_enable=0, busy=0, state_valid=0, timeout_err=0, ctrl_state=32'h0.
REQ-031 Reset during TX_BIT SHALL release the line by the first edge with reset high; no partial command resumes.

Configuration
REQ-032 Macro N64_POLL_ERRCNT_EN defined: add output err_cnt [7:0], reset 0, +1 per timeout_err, saturating at 255, cleared to 0 on state_valid.
REQ-033 Macro undefined: err_cnt port and logic absent; all other behaviour identical.

Verification
REQ-034 poll_req in IDLE -> dout_oe high 33 cycles; dout pattern 0001 x7, then 0111, then 0; next cycle rx_enable=1.
REQ-035 rx_done raised 100 cycles into WAIT_RESP with rx_state=32'h8000_00FF -> ctrl_state=32'h8000_00FF and state_valid pulse 2-3 cycles later; GAP lasts 8 cycles; busy low.
REQ-036 No rx_done -> timeout_err pulse exactly 800 cycles after WAIT_RESP entry; ctrl_state unchanged; with macro, err_cnt=1.
REQ-037 poll_req asserted in TX_BIT and in GAP -> no extra transaction; POLL_TICKS=100: free-running triggers 100 cycles apart.
REQ-038 reset at cycle 10 of TX_BIT -> dout_oe=0, all outputs at reset values next edge; with macro, 256 timeouts -> err_cnt stays 255; one valid response -> err_cnt=0.
